// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core front end.
// FSM encodings, response codes and fetch defaults.
package npc_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_NPC  = 3'd4;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_ZERO    = 32'h0000_0000;

  function automatic logic misaligned(
    input logic [31:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// RV32E instruction fetch unit: one fetch in flight,
// PC held here, word handed to decode, next PC taken back.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_arvalid,
  output logic [31:0] imem_araddr,
  input  logic        imem_arready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  output logic        imem_rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        npc_ready,
  output logic [31:0] perf_fetch_cnt
);

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic        fault_q;
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      inst_q  <= INST_ZERO;
      fault_q <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): state <= S_REQ;
        (state == S_REQ): begin
          if (imem_arready) state <= S_RESP;
        end
        (state == S_RESP): begin
          if (imem_rvalid) begin
            if (imem_rresp == RESP_OKAY) begin
              inst_q  <= imem_rdata;
              fault_q <= 1'b0;
            end else begin
              inst_q  <= INST_ZERO;
              fault_q <= 1'b1;
            end
            state <= S_OUT;
          end
        end
        (state == S_OUT): begin
          if (out_ready) begin
            cnt   <= cnt + 32'd1;
            state <= S_NPC;
          end
        end
        (state == S_NPC): begin
          if (npc_valid) begin
            pc <= npc;
            // a misaligned target never reaches memory
            if (misaligned(npc)) begin
              inst_q  <= INST_ZERO;
              fault_q <= 1'b1;
              state   <= S_OUT;
            end else begin
              state <= S_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_arvalid   = (state == S_REQ);
  assign imem_rready    = (state == S_RESP);
  assign out_valid      = (state == S_OUT);
  assign npc_ready      = (state == S_NPC);
  assign imem_araddr    = pc;
  assign out_pc         = pc;
  assign out_inst       = inst_q;
  assign out_fault      = fault_q;
  assign perf_fetch_cnt = cnt;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed plus randomized bench for ifu_fetch against a
// transaction-level model of PC, delivered word and counter.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        npc_valid;
  logic [31:0] npc;
  logic        npc_ready;
  logic [31:0] perf_fetch_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_arvalid   (imem_arvalid),
    .imem_araddr    (imem_araddr),
    .imem_arready   (imem_arready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .imem_rresp     (imem_rresp),
    .imem_rready    (imem_rready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .npc_valid      (npc_valid),
    .npc            (npc),
    .npc_ready      (npc_ready),
    .perf_fetch_cnt (perf_fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Enters in the address phase, leaves with the word on offer.
  task automatic do_mem(
    input logic [31:0] word,
    input logic [1:0]  resp,
    input int          ar_d,
    input int          r_d
  );
    chk("arvalid", {31'd0, imem_arvalid}, 32'd1);
    chk("araddr", imem_araddr, m_pc);
    for (int i = 0; i < ar_d; i++) begin
      imem_arready = 1'b0;
      imem_rvalid  = 1'($urandom);
      step();
      chk("ar_hold", {31'd0, imem_arvalid}, 32'd1);
      chk("araddr_stable", imem_araddr, m_pc);
    end
    imem_rvalid  = 1'b0;
    imem_arready = 1'b1;
    step();
    imem_arready = 1'b0;
    chk("ar_drop", {31'd0, imem_arvalid}, 32'd0);
    chk("rready", {31'd0, imem_rready}, 32'd1);
    for (int i = 0; i < r_d; i++) begin
      imem_arready = 1'($urandom);
      step();
      chk("r_wait", {30'd0, imem_rready, out_valid}, 32'd2);
    end
    imem_arready = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rdata   = word;
    imem_rresp   = resp;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    imem_rresp  = 2'($urandom);
  endtask

  // Enters with the word on offer, leaves waiting for a next PC.
  task automatic do_out(
    input logic [31:0] inst,
    input logic        fault,
    input int          o_d
  );
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_inst", out_inst, inst);
    chk("out_pc", out_pc, m_pc);
    chk("out_fault", {31'd0, out_fault}, {31'd0, fault});
    for (int i = 0; i < o_d; i++) begin
      out_ready    = 1'b0;
      imem_arready = 1'($urandom);
      imem_rvalid  = 1'($urandom);
      imem_rdata   = $urandom;
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_inst", out_inst, inst);
      chk("bp_pc", out_pc, m_pc);
      chk("bp_npc_ready", {31'd0, npc_ready}, 32'd0);
      chk("bp_cnt", perf_fetch_cnt, m_cnt);
    end
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    out_ready    = 1'b1;
    step();
    out_ready = 1'b0;
    m_cnt     = m_cnt + 32'd1;
    chk("cnt", perf_fetch_cnt, m_cnt);
    chk("npc_ready", {31'd0, npc_ready}, 32'd1);
  endtask

  task automatic do_npc(
    input logic [31:0] nxt,
    input int          n_d
  );
    for (int i = 0; i < n_d; i++) begin
      npc_valid = 1'b0;
      npc       = $urandom;
      step();
      chk("npc_wait", {31'd0, npc_ready}, 32'd1);
      chk("npc_pc", out_pc, m_pc);
    end
    npc_valid = 1'b1;
    npc       = nxt;
    step();
    npc_valid = 1'b0;
    m_pc      = nxt;
    if (nxt[1:0] == 2'b00) begin
      chk("next_req", {31'd0, imem_arvalid}, 32'd1);
    end else begin
      chk("mis_noar", {31'd0, imem_arvalid}, 32'd0);
    end
  endtask

  task automatic check_reset();
    chk("rst_hs", {28'd0, imem_arvalid, imem_rready,
                   out_valid, npc_ready}, 32'd0);
    chk("rst_araddr", imem_araddr, RST_PC);
    chk("rst_out_pc", out_pc, RST_PC);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_fault", {31'd0, out_fault}, 32'd0);
    chk("rst_cnt", perf_fetch_cnt, 32'd0);
  endtask

  task automatic full_fetch(
    input logic [31:0] word,
    input logic [1:0]  resp,
    input int ar_d, input int r_d,
    input int o_d, input int n_d,
    input logic [31:0] nxt
  );
    do_mem(word, resp, ar_d, r_d);
    do_out((resp == 2'b00) ? word : 32'd0,
           resp != 2'b00, o_d);
    do_npc(nxt, n_d);
    while (nxt[1:0] != 2'b00) begin
      do_out(32'd0, 1'b1, 0);
      nxt = {$urandom} & 32'hFFFF_FFFC;
      do_npc(nxt, 0);
    end
  endtask

  initial begin
    int t0;
    int lat0;
    int lat1;
    rst_n        = 1'b0;
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'd0;
    imem_rresp   = 2'b00;
    out_ready    = 1'b0;
    npc_valid    = 1'b0;
    npc          = 32'd0;
    m_pc         = RST_PC;
    m_cnt        = 32'd0;
    step();
    step();
    check_reset();
    rst_n = 1'b1;
    chk("idle_noar", {31'd0, imem_arvalid}, 32'd0);
    step();

    // zero-wait first fetch, with latency measured
    t0 = $time;
    do_mem(32'h0000_0413, 2'b00, 0, 0);
    lat0 = ($time - t0) / 10;
    do_out(32'h0000_0413, 1'b0, 0);
    do_npc(32'h8000_0004, 0);

    // memory stalls: 3 on address, 2 on data
    t0 = $time;
    do_mem(32'h1234_5678, 2'b00, 3, 2);
    lat1 = ($time - t0) / 10;
    chk("stall_latency", lat1, lat0 + 5);
    // decode backpressure
    do_out(32'h1234_5678, 1'b0, 4);
    // misaligned next PC
    do_npc(32'h8000_0006, 0);
    chk("mis_valid", {31'd0, out_valid}, 32'd1);
    do_out(32'd0, 1'b1, 0);
    do_npc(32'h8000_0008, 1);

    // bus error then OKAY fetch clears the fault
    full_fetch(32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0,
               32'h8000_000C);
    full_fetch(32'h0050_0093, 2'b00, 0, 0, 0, 0,
               32'h8000_0010);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [31:0] nxt;
      nxt = $urandom;
      if ($urandom_range(0, 3) != 0) nxt[1:0] = 2'b00;
      full_fetch($urandom, 2'($urandom_range(0, 3) == 0 ?
                 $urandom_range(1, 3) : 0),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2),
                 nxt);
    end

    // reset in the data phase, then a late rvalid
    imem_arready = 1'b1;
    step();
    imem_arready = 1'b0;
    chk("pre_rst_rready", {31'd0, imem_rready}, 32'd1);
    rst_n = 1'b0;
    step();
    m_pc  = RST_PC;
    m_cnt = 32'd0;
    check_reset();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    step();
    chk("late_rready", {31'd0, imem_rready}, 32'd0);
    chk("late_araddr", imem_araddr, RST_PC);
    chk("late_inst", out_inst, 32'd0);
    chk("late_cnt", perf_fetch_cnt, 32'd0);
    imem_rvalid = 1'b0;
    full_fetch(32'h0000_0413, 2'b00, 0, 0, 0, 0,
               32'h8000_0004);
    chk("final_cnt", perf_fetch_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
